// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SAR = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/param_seq_alu_iter_datapath.sv
// Multi-cycle engine: signed radix-2 Booth multiply and unsigned restoring divide,
// one step per clock, sharing the A/Q/M registers and the step counter.
module iter_datapath #(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         is_div,
  input  logic         step,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         last,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  // A carries one guard bit so Booth add/sub of the most negative M stays exact
  logic [W:0]    a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic          q1_q, q1_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    m_ext_s;
  logic [W:0]    booth_sum_s;
  logic [W:0]    a_sh_s;
  logic [W+1:0]  diff_s;

  // next-state for one Booth or restoring-division step
  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    q1_d  = q1_q;
    div_d = div_q;
    cnt_d = cnt_q;

    m_ext_s = {m_q[W-1], m_q};
    case ({q_q[0], q1_q})
      2'b01:   booth_sum_s = a_q + m_ext_s;
      2'b10:   booth_sum_s = a_q - m_ext_s;
      default: booth_sum_s = a_q;
    endcase
    a_sh_s = {a_q[W-1:0], q_q[W-1]};
    diff_s = {1'b0, a_sh_s} - {2'b00, m_q};

    if (load) begin
      a_d   = {(W+1){1'b0}};
      q_d   = in1;
      m_d   = in2;
      q1_d  = 1'b0;
      div_d = is_div;
      cnt_d = {CW{1'b0}};
    end else if (step) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      if (div_q) begin
        if (diff_s[W+1]) begin
          a_d = a_sh_s;
          q_d = {q_q[W-2:0], 1'b0};
        end else begin
          a_d = diff_s[W:0];
          q_d = {q_q[W-2:0], 1'b1};
        end
      end else begin
        a_d  = {booth_sum_s[W], booth_sum_s[W:1]};
        q_d  = {booth_sum_s[0], q_q[W-1:1]};
        q1_d = q_q[0];
      end
    end else begin
      a_d = a_q;
    end
  end

  // engine registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= {(W+1){1'b0}};
      q_q   <= {W{1'b0}};
      m_q   <= {W{1'b0}};
      q1_q  <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= {CW{1'b0}};
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      q1_q  <= q1_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  // results are taken from next-state so the top can latch them on the final step edge
  assign last   = step & (cnt_q == CW'(W - 1));
  assign res_hi = a_d[W-1:0];
  assign res_lo = q_d;

endmodule

// File: rtl/param_seq_alu.sv
// Sequential ALU top: IDLE/ITER/DONE control, single-cycle ops and flag generation.
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    in1,
  input  logic [W-1:0]    in2,
  output logic [2*W-1:0]  result,
  output logic            busy,
  output logic            done,
  output logic            c,
  output logic            z,
  output logic            v,
  output logic            n,
  output logic            dz
);

  localparam logic [W-1:0] W_VAL = W'(W);

  state_e         state_q, state_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [2*W-1:0] result_q, result_d;
  logic           c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d, dz_q, dz_d;
  logic           mul_q, mul_d;

  logic [CW-1:0]  sh_s;
  logic [W:0]     add_s, sub_s, shl_s, sar_s;
  logic [W-1:0]   sc_lo, sc_hi;
  logic           sc_c, sc_v, sc_dz;
  logic           div_nz_s, iter_op_s;
  logic           dp_load_s, dp_step_s, dp_last_s;
  logic [W-1:0]   dp_hi_s, dp_lo_s;

  assign div_nz_s  = (op == OP_DIV) && (in2 != {W{1'b0}});
  assign iter_op_s = (op == OP_MUL) || div_nz_s;
  assign dp_load_s = (state_q == ST_IDLE) && start && iter_op_s;
  assign dp_step_s = (state_q == ST_ITER);

  iter_datapath #(.W(W), .CW(CW)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load_s),
    .is_div (op == OP_DIV),
    .step   (dp_step_s),
    .in1    (in1),
    .in2    (in2),
    .last   (dp_last_s),
    .res_hi (dp_hi_s),
    .res_lo (dp_lo_s)
  );

  // single-cycle operation results, evaluated on the live inputs at the accepting edge
  always_comb begin
    sh_s  = CW'(in2 % W_VAL);
    add_s = {1'b0, in1} + {1'b0, in2};
    sub_s = {1'b0, in1} + {1'b0, ~in2} + {{W{1'b0}}, 1'b1};
    shl_s = {1'b0, in1} << sh_s;
    sar_s = $signed({in1, 1'b0}) >>> sh_s;
    sc_lo = {W{1'b0}};
    sc_hi = {W{1'b0}};
    sc_c  = 1'b0;
    sc_v  = 1'b0;
    sc_dz = 1'b0;
    case (op)
      OP_ADD: begin
        sc_lo = add_s[W-1:0];
        sc_c  = add_s[W];
        sc_v  = (in1[W-1] == in2[W-1]) && (sc_lo[W-1] != in1[W-1]);
      end
      OP_SUB: begin
        sc_lo = sub_s[W-1:0];
        sc_c  = sub_s[W];
        sc_v  = (in1[W-1] != in2[W-1]) && (sc_lo[W-1] != in1[W-1]);
      end
      OP_AND: sc_lo = in1 & in2;
      OP_OR:  sc_lo = in1 | in2;
      OP_XOR: sc_lo = in1 ^ in2;
      OP_NOT: sc_lo = ~in1;
      OP_SHL: begin
        sc_lo = shl_s[W-1:0];
        sc_c  = shl_s[W];
      end
      OP_SAR: begin
        sc_lo = sar_s[W:1];
        sc_c  = sar_s[0];
      end
      OP_DIV: begin
        sc_lo = {W{1'b1}};
        sc_hi = in1;
        sc_dz = 1'b1;
      end
      default: sc_lo = {W{1'b0}};
    endcase
  end

  // control next-state; outputs only change on entry to DONE or on leaving it
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    dz_d     = dz_q;
    mul_d    = mul_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (iter_op_s) begin
            state_d = ST_ITER;
            mul_d   = (op == OP_MUL);
          end else begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = {sc_hi, sc_lo};
            c_d      = sc_c;
            z_d      = (sc_lo == {W{1'b0}});
            v_d      = sc_v;
            n_d      = sc_lo[W-1];
            dz_d     = sc_dz;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (dp_last_s) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = {dp_hi_s, dp_lo_s};
          c_d      = 1'b0;
          v_d      = 1'b0;
          dz_d     = 1'b0;
          z_d      = mul_q ? ({dp_hi_s, dp_lo_s} == {(2*W){1'b0}}) : (dp_lo_s == {W{1'b0}});
          n_d      = mul_q ? dp_hi_s[W-1] : dp_lo_s[W-1];
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {(2*W){1'b0}};
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      dz_q     <= 1'b0;
      mul_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      dz_q     <= dz_d;
      mul_q    <= mul_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign c      = c_q;
  assign z      = z_q;
  assign v      = v_q;
  assign n      = n_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed self-checking bench for param_seq_alu at W=16.
module tb_param_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] in1 = 16'd0;
  logic [15:0] in2 = 16'd0;
  logic [31:0] result;
  logic        busy, done, c, z, v, n, dz;

  int errors = 0;
  int checks = 0;
  int edges;
  int done_cnt;

  param_seq_alu #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .result(result), .busy(busy), .done(done),
    .c(c), .z(z), .v(v), .n(n), .dz(dz)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flags();
    return {27'd0, c, z, v, n, dz};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one op, scramble inputs after the accept edge, count edges until done
  task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int e);
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1'b1;
    e = 0;
    do begin
      @(negedge clk);
      e++;
      start = 1'b0; in1 = ~a; in2 = ~b; op = 4'd15;
    end while (done !== 1'b1 && e < 40);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", {30'd0, busy, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_flags", flags(), 32'd0);

    // reset has priority over start
    start = 1'b1; op = 4'd0; in1 = 16'd1; in2 = 16'd1;
    @(negedge clk);
    chk("rst_prio", {30'd0, busy, done}, 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    run_op(4'd0, 16'h7FFF, 16'h0001, edges);
    chk("add_ovf_res", result, 32'h0000_8000);
    chk("add_ovf_flags", flags(), 32'h06);
    chk("add_lat", edges, 32'd1);
    chk("add_busy", {31'd0, busy}, 32'd1);

    run_op(4'd0, 16'hFFFF, 16'h0001, edges);
    chk("add_carry_res", result, 32'h0000_0000);
    chk("add_carry_flags", flags(), 32'h18);

    run_op(4'd1, 16'h0005, 16'h0005, edges);
    chk("sub_zero_res", result, 32'h0000_0000);
    chk("sub_zero_flags", flags(), 32'h18);

    run_op(4'd1, 16'h0003, 16'h0005, edges);
    chk("sub_borrow_res", result, 32'h0000_FFFE);
    chk("sub_borrow_flags", flags(), 32'h02);

    run_op(4'd1, 16'h8000, 16'h0001, edges);
    chk("sub_ovf_res", result, 32'h0000_7FFF);
    chk("sub_ovf_flags", flags(), 32'h14);

    run_op(4'd7, 16'h8001, 16'h0001, edges);
    chk("sar_res", result, 32'h0000_C000);
    chk("sar_flags", flags(), 32'h12);

    run_op(4'd6, 16'h8001, 16'h0011, edges);
    chk("shl_mod_res", result, 32'h0000_0002);
    chk("shl_mod_flags", flags(), 32'h10);

    run_op(4'd6, 16'h1234, 16'h0010, edges);
    chk("shl_zero_res", result, 32'h0000_1234);
    chk("shl_zero_flags", flags(), 32'h00);

    run_op(4'd2, 16'hF0F0, 16'h0FF0, edges);
    chk("and_res", result, 32'h0000_00F0);

    run_op(4'd4, 16'hF0F0, 16'h0FF0, edges);
    chk("xor_res", result, 32'h0000_FF00);

    run_op(4'd5, 16'h00FF, 16'h1234, edges);
    chk("not_res", result, 32'h0000_FF00);
    chk("not_flags", flags(), 32'h02);

    run_op(4'd12, 16'h1234, 16'h5678, edges);
    chk("rsvd_res", result, 32'h0000_0000);
    chk("rsvd_flags", flags(), 32'h08);
    chk("rsvd_lat", edges, 32'd1);

    run_op(4'd8, 16'h0045, 16'h002A, edges);
    chk("mul_pos_res", result, 32'h0000_0B52);
    chk("mul_pos_flags", flags(), 32'h00);
    chk("mul_lat", edges, 32'd17);

    run_op(4'd8, 16'hFFFD, 16'h0005, edges);
    chk("mul_neg_res", result, 32'hFFFF_FFF1);
    chk("mul_neg_flags", flags(), 32'h02);

    run_op(4'd8, 16'h8000, 16'h8000, edges);
    chk("mul_min_res", result, 32'h4000_0000);

    run_op(4'd9, 16'h0045, 16'h002A, edges);
    chk("div_res", result, 32'h001B_0001);
    chk("div_flags", flags(), 32'h00);
    chk("div_lat", edges, 32'd17);

    run_op(4'd9, 16'h0045, 16'h0000, edges);
    chk("div0_res", result, 32'h0045_FFFF);
    chk("div0_flags", flags(), 32'h03);
    chk("div0_lat", edges, 32'd1);

    // done is a single pulse and the result holds afterwards
    repeat (2) @(negedge clk);
    chk("post_ctl", {30'd0, busy, done}, 32'd0);
    chk("post_hold", result, 32'h0045_FFFF);

    // start ignored mid-ITER, then reset mid-ITER
    op = 4'd8; in1 = 16'h0045; in2 = 16'h002A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 4'd0; in1 = 16'h0001; in2 = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_ctl", {30'd0, busy, done}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctl", {30'd0, busy, done}, 32'd0);
    chk("midrst_res", result, 32'd0);
    chk("midrst_flags", flags(), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("midrst_nodone", done_cnt, 32'd0);

    // counter restarts cleanly after the aborted operation
    run_op(4'd8, 16'h0045, 16'h002A, edges);
    chk("recov_res", result, 32'h0000_0B52);
    chk("recov_lat", edges, 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 SHALL have parameter W, default 16, operand width in bits (legal 4..64).
REQ-002 SHALL have parameter CW, default $clog2(W)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SAR, 8 MUL, 9 DIV; 10..15 reserved.
REQ-007 SHALL have port in1  input  W  operand A, dividend, or shifted value.
REQ-008 SHALL have port in2  input  W  operand B, divisor, or shift amount (low CW-1 bits).
REQ-009 SHALL have port result  output  2W  {hi,lo}: MUL {product}, DIV {remainder,quotient}, others {W'0,value}.
REQ-010 SHALL have port busy  output  1  high from accept until done.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have ports c, z, v, n, dz  output  1 each  carry, zero, overflow, negative, divide-by-zero flags.

Function
REQ-013 SHALL capture op, in1 and in2 at the accepting edge; later input changes have no effect on the operation.
REQ-014 SHALL use FSM states IDLE, ITER, DONE; IDLE->DONE on accept of op 0-7 or reserved; IDLE->ITER on accept of MUL/DIV; ITER->DONE after W steps; DONE->IDLE unconditionally.
REQ-015 SHALL assert done=1 only in DONE; busy=1 in ITER and DONE.
REQ-016 Latency: done SHALL be high in the cycle after the accepting edge for ops 0-7, and after the W-th ITER edge for MUL/DIV (W+1 edges after accept).
REQ-017 SHALL ignore start while busy=1 and SHALL NOT queue it.
REQ-018 ADD/SUB SHALL be two's complement W-bit; c = carry out (SUB: c=1 means no borrow); v = signed overflow.
REQ-019 SHL/SAR SHALL shift by in2 mod W; c = last bit shifted out, 0 for a shift by 0.
REQ-020 MUL SHALL be signed radix-2 Booth, one step per cycle, 2W-bit exact result; c=v=0.
REQ-021 DIV SHALL be unsigned restoring division, one quotient bit per cycle.
REQ-022 DIV with in2=0 SHALL skip ITER, go directly to DONE, set dz=1, quotient all ones, remainder in1.
REQ-023 z SHALL reflect the whole 2W result for MUL and lo only otherwise; n SHALL be the MSB of the same field.
REQ-024 Reserved ops SHALL complete in 1 cycle with result 0, z=1, all other flags 0.
REQ-025 result and flags SHALL update only on entry to DONE and hold until the next DONE.
REQ-026 Logic ops and NOT SHALL clear c and v.

Reset
REQ-027 rst=1 SHALL force IDLE, busy=0, done=0, result=0, c=z=v=n=dz=0 and counter=0 at the next edge, including mid-ITER.
REQ-028 rst SHALL take priority over a simultaneous start; no operation is accepted while rst=1.

Structure
REQ-029 Shared package alu_pkg SHALL hold the op enumeration, the state enumeration and the opcode width constant.
REQ-030 A sub-module iter_datapath (W-parameterised A/Q/M registers, Booth/restore step, counter) SHALL hold the MUL/DIV iteration; the top holds the FSM, single-cycle ops and flags.

Verification (W=16)
REQ-031 MUL in1=0x0045, in2=0x002A -> result 0x00000B52, z=0, n=0, done exactly 17 edges after accept.
REQ-032 MUL in1=0xFFFD, in2=0x0005 -> result 0xFFFFFFF1, n=1.
REQ-033 DIV in1=0x0045, in2=0x002A -> quotient 0x0001, remainder 0x001B; DIV by 0x0000 -> dz=1, quotient 0xFFFF, remainder 0x0045, done 1 cycle after accept.
REQ-034 ADD 0x7FFF+0x0001 -> lo 0x8000, v=1, n=1, c=0; SUB 0x0005-0x0005 -> z=1, c=1.
REQ-035 Start a MUL, pulse start with a new op at ITER cycle 3 -> the pulse is ignored; rst=1 at ITER cycle 5 -> IDLE, all outputs 0 next edge, no done pulse.
REQ-036 SAR in1=0x8001, in2=0x0001 -> lo 0xC000, c=1, n=1.
